if_id_queue: RTL and testbench

IF_ID_QUEUE -- requirements
Module: if_id_queue

---
 rtl/if_id_queue.sv | 119 +++++++++++
 tb/tb_if_id_queue.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry FIFO of {instr, pc} with flush.
// Optional IFQ_BYPASS_EN macro adds a zero-latency path from fetch to decode when empty.
module if_id_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_instr,
   input  logic [WIDTH-1:0]         in_pc,
   output logic                     in_ready,
   input  logic                     flush,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_instr,
   output logic [WIDTH-1:0]         out_pc,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

   logic [WIDTH-1:0] instr_mem_q [DEPTH];
   logic [WIDTH-1:0] pc_mem_q    [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic empty;
   logic full;
   logic push;
   logic pop;
   logic bypass_take;
   logic wr_en;
   logic rd_en;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(DEPTH));
   assign in_ready = !full;
   assign count    = count_q;

   // Head presentation; the stored head is only exposed while the queue holds entries.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      out_valid = !empty;
      out_instr = NOP;
      out_pc    = '0;
      if (!empty) begin
         out_instr = instr_mem_q[rd_ptr_q];
         out_pc    = pc_mem_q[rd_ptr_q];
      end
`ifdef IFQ_BYPASS_EN
      if (empty && !flush && reset) begin
         out_valid = in_valid;
         if (in_valid) begin
            out_instr = in_instr;
            out_pc    = in_pc;
         end
      end
`endif
   end

   assign push = in_valid && in_ready && !flush;
   assign pop  = out_valid && out_ready && !flush;

`ifdef IFQ_BYPASS_EN
   // An instruction handed straight to decode never occupies an entry.
   assign bypass_take = empty && push && pop;
`else
   assign bypass_take = 1'b0;
`endif

   assign wr_en = push && !bypass_take;
   assign rd_en = pop  && !bypass_take;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; entries are unobservable while count is 0.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         instr_mem_q[wr_ptr_q] <= in_instr;
         pc_mem_q[wr_ptr_q]    <= in_pc;
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue (default build): a reference queue tracks every
// accepted push and checks the head, count and handshakes each cycle.
module tb_if_id_queue;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic [WIDTH-1:0] in_instr;
   logic [WIDTH-1:0] in_pc;
   logic             in_ready;
   logic             flush;
   logic             out_valid;
   logic [WIDTH-1:0] out_instr;
   logic [WIDTH-1:0] out_pc;
   logic             out_ready;
   logic [CNT_W-1:0] count;

   entry_t sb[$];
   int checks   = 0;
   int failures = 0;

   if_id_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_instr  (in_instr),
      .in_pc     (in_pc),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_valid (out_valid),
      .out_instr (out_instr),
      .out_pc    (out_pc),
      .out_ready (out_ready),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return pc ^ 32'h00A0_0093;
   endfunction

   // Called at posedge+1: drive, sample at the falling edge, update the model, move to next posedge+1.
   task automatic cycle(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
      logic exp_push;
      logic exp_pop;
      in_valid  = iv;
      in_pc     = pc;
      in_instr  = instr_of(pc);
      out_ready = ordy;
      flush     = fl;
      #4;
      check("count",     64'(count),     64'(sb.size()));
      check("in_ready",  64'(in_ready),  64'(sb.size() != DEPTH));
      check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      if (sb.size() != 0) begin
         check("head_pc",    64'(out_pc),    64'(sb[0].pc));
         check("head_instr", 64'(out_instr), 64'(sb[0].instr));
      end else begin
         check("idle_pc",    64'(out_pc),    64'(0));
         check("idle_instr", 64'(out_instr), 64'(NOP));
      end
      exp_push = iv && (sb.size() != DEPTH) && !fl;
      exp_pop  = (sb.size() != 0) && ordy && !fl;
      if (fl) sb.delete();
      else begin
         if (exp_pop)  void'(sb.pop_front());
         if (exp_push) sb.push_back('{instr: instr_of(pc), pc: pc});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      #2;
      check("rst_count",     64'(count),     64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_in_ready",  64'(in_ready),  64'(1));
      check("rst_out_instr", 64'(out_instr), 64'(NOP));
      check("rst_out_pc",    64'(out_pc),    64'(0));
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Fill to DEPTH, then a fifth request must be refused.
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'(4 * i), 1'b0, 1'b0);
      cycle(1'b1, 32'h10, 1'b0, 1'b0);
      check("full_count", 64'(count), 64'(4));

      // Drain in order, then confirm the idle NOP head.
      for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);

      // Steady simultaneous push/pop at count 2 across several pointer wraps.
      cycle(1'b1, 32'h100, 1'b0, 1'b0);
      cycle(1'b1, 32'h104, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cycle(1'b1, 32'h10 + 32'(4 * i), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

      // Flush with a concurrent push: nothing survives, pointers restart.
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
      cycle(1'b1, 32'h20, 1'b1, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      cycle(1'b1, 32'h300, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);

      // Asynchronous reset between edges with two entries held.
      cycle(1'b1, 32'h350, 1'b0, 1'b0);
      cycle(1'b1, 32'h354, 1'b0, 1'b0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("async_count",     64'(count),     64'(0));
      check("async_out_valid", 64'(out_valid), 64'(0));
      check("async_in_ready",  64'(in_ready),  64'(1));
      check("async_out_instr", 64'(out_instr), 64'(NOP));
      sb.delete();
      @(posedge clk);
      #1;
      reset = 1'b1;
      cycle(1'b1, 32'h400, 1'b0, 1'b0);
      cycle(1'b1, 32'h404, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 300; i++)
         cycle(1'($urandom_range(0, 1)), 32'h1000 + 32'(4 * i),
               1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
      for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
